// File: rtl/md4_arbiter.sv
// md4_arbiter: round-robin front end that shares one md4block between
// NUM_REQ requester lanes. One block is in flight at a time; the FSM drives
// the md4block trigger handshake and reports per-lane completion.

// Per-lane grant flop and completion pulse.
module md4_arb_lane #(
  parameter int PW   = 2,
  parameter int LANE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [PW-1:0] sel,
  input  logic          in_done,
  output logic          gnt,
  output logic          done
);

  // grant is taken when this lane wins arbitration, dropped at completion
  always_ff @(posedge clk) begin
    if (rst)        gnt <= 1'b0;
    else if (load)  gnt <= (sel == PW'(LANE));
    else if (clear) gnt <= 1'b0;
  end

  assign done = gnt & in_done;

endmodule

module md4_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IRDY_HOLD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [512*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [127:0]           result,
  output logic [31:0]            hashes_done,
  output logic                   md4_irdy,
  output logic [31:0]            md4_in_a,
  output logic [31:0]            md4_in_b,
  output logic [31:0]            md4_in_c,
  output logic [31:0]            md4_in_d,
  output logic [511:0]           md4_data,
  input  logic                   md4_ordy,
  input  logic [31:0]            md4_out_a,
  input  logic [31:0]            md4_out_b,
  input  logic [31:0]            md4_out_c,
  input  logic [31:0]            md4_out_d
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG    = 3'd1;
  localparam logic [2:0] S_LOWER   = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] lane_q;
  logic [3:0]    hold_cnt;
  logic          any_req;
  logic          load;
  logic          st_done;

  // first requesting lane at or after rr_ptr, wrapping around
  always_comb begin : p_pick
    int idx;
    idx     = 0;
    sel     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        sel     = PW'(idx);
      end
    end
  end

  assign load     = (state == S_IDLE) && any_req;
  assign st_done  = (state == S_DONE);
  assign md4_irdy = (state == S_TRIG);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    md4_arb_lane #(.PW(PW), .LANE(i)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .clear   (st_done),
      .sel     (sel),
      .in_done (st_done),
      .gnt     (gnt[i]),
      .done    (done[i])
    );
  end

  // control FSM: grant, trigger handshake, ordy low-then-high, completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      lane_q      <= '0;
      hold_cnt    <= '0;
      md4_in_a    <= '0;
      md4_in_b    <= '0;
      md4_in_c    <= '0;
      md4_in_d    <= '0;
      md4_data    <= '0;
      result      <= '0;
      hashes_done <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            lane_q   <= sel;
            md4_data <= req_data[512*sel +: 512];
            md4_in_a <= 32'h67452301;
            md4_in_b <= 32'hefcdab89;
            md4_in_c <= 32'h98badcfe;
            md4_in_d <= 32'h10325476;
            hold_cnt <= 4'(IRDY_HOLD);
            state    <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (hold_cnt <= 4'd1) begin
            hold_cnt <= '0;
            state    <= S_LOWER;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        S_LOWER: state <= S_WAIT_LO;
        // an ordy still high from the previous block must fall first
        S_WAIT_LO: if (!md4_ordy) state <= S_WAIT_HI;
        S_WAIT_HI: begin
          if (md4_ordy) begin
            result <= {md4_out_a, md4_out_b, md4_out_c, md4_out_d};
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          hashes_done <= hashes_done + 32'd1;
          rr_ptr      <= (lane_q == PW'(NUM_REQ - 1)) ? '0 : lane_q + PW'(1);
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md4_arbiter.sv
// tb_md4_arbiter: random and directed stimulus against a transaction-level
// arbitration model plus a behavioural md4block stub and MD4 reference.
module tb_md4_arbiter;
  localparam int NR   = 4;
  localparam int HOLD = 2;
  localparam logic [31:0] IA = 32'h67452301;
  localparam logic [31:0] IB = 32'hefcdab89;
  localparam logic [31:0] IC = 32'h98badcfe;
  localparam logic [31:0] ID = 32'h10325476;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_h = '0;
  logic [512*NR-1:0] req_data = '0;
  logic [NR-1:0]     gnt, done;
  logic [127:0]      result;
  logic [31:0]       hashes_done, md4_in_a, md4_in_b, md4_in_c, md4_in_d;
  logic              md4_irdy;
  logic [511:0]      md4_data;
  logic              md4_ordy = 1'b1;
  logic [31:0]       md4_out_a = '0, md4_out_b = '0, md4_out_c = '0, md4_out_d = '0;

  logic [NR-1:0] gnt_h1, done_h1, gnt_h15, done_h15;
  logic [127:0]  res_h1, res_h15;
  logic [31:0]   hd_h1, ia_h1, ib_h1, ic_h1, id_h1, hd_h15, ia_h15, ib_h15, ic_h15, id_h15;
  logic          irdy_h1, irdy_h15;
  logic [511:0]  dat_h1, dat_h15;

  md4_arbiter #(.NUM_REQ(NR), .IRDY_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .result(result), .hashes_done(hashes_done), .md4_irdy(md4_irdy),
    .md4_in_a(md4_in_a), .md4_in_b(md4_in_b), .md4_in_c(md4_in_c), .md4_in_d(md4_in_d),
    .md4_data(md4_data), .md4_ordy(md4_ordy),
    .md4_out_a(md4_out_a), .md4_out_b(md4_out_b), .md4_out_c(md4_out_c), .md4_out_d(md4_out_d));

  md4_arbiter #(.NUM_REQ(NR), .IRDY_HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req_h), .req_data(req_data), .gnt(gnt_h1), .done(done_h1),
    .result(res_h1), .hashes_done(hd_h1), .md4_irdy(irdy_h1),
    .md4_in_a(ia_h1), .md4_in_b(ib_h1), .md4_in_c(ic_h1), .md4_in_d(id_h1),
    .md4_data(dat_h1), .md4_ordy(1'b0),
    .md4_out_a(32'h0), .md4_out_b(32'h0), .md4_out_c(32'h0), .md4_out_d(32'h0));

  md4_arbiter #(.NUM_REQ(NR), .IRDY_HOLD(15)) u_h15 (
    .clk(clk), .rst(rst), .req(req_h), .req_data(req_data), .gnt(gnt_h15), .done(done_h15),
    .result(res_h15), .hashes_done(hd_h15), .md4_irdy(irdy_h15),
    .md4_in_a(ia_h15), .md4_in_b(ib_h15), .md4_in_c(ic_h15), .md4_in_d(id_h15),
    .md4_data(dat_h15), .md4_ordy(1'b0),
    .md4_out_a(32'h0), .md4_out_b(32'h0), .md4_out_c(32'h0), .md4_out_d(32'h0));

  // MD4 compression of one block, straight from the algorithm definition
  function automatic logic [127:0] md4_fn(input logic [31:0] ia, ib, ic, id,
                                          input logic [511:0] blk);
    logic [31:0] x [16];
    logic [31:0] a, b, c, d, t, f;
    logic [3:0]  iv;
    int k, s;
    for (int j = 0; j < 16; j++) x[j] = blk[32*j +: 32];
    a = ia; b = ib; c = ic; d = id;
    for (int i = 0; i < 48; i++) begin
      iv = 4'(i);
      if (i < 16) begin
        f = (b & c) | (~b & d);
        k = i;
        s = (i % 4 == 0) ? 3 : (i % 4 == 1) ? 7 : (i % 4 == 2) ? 11 : 19;
        t = a + f + x[k];
      end else if (i < 32) begin
        f = (b & c) | (b & d) | (c & d);
        k = (i % 4) * 4 + (i % 16) / 4;
        s = (i % 4 == 0) ? 3 : (i % 4 == 1) ? 5 : (i % 4 == 2) ? 9 : 13;
        t = a + f + x[k] + 32'h5a827999;
      end else begin
        f = b ^ c ^ d;
        k = int'({iv[0], iv[1], iv[2], iv[3]});
        s = (i % 4 == 0) ? 3 : (i % 4 == 1) ? 9 : (i % 4 == 2) ? 11 : 15;
        t = a + f + x[k] + 32'h6ed9eba1;
      end
      t = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = t;
    end
    return {a + ia, b + ib, c + ic, d + id};
  endfunction

  // md4block stub: ordy stays stale for stale_len cycles after the trigger,
  // then low, then high lat cycles after irdy has fallen
  int stale_len = 0, lat = 3, ph = 0, scnt = 0;
  logic irdy_q = 1'b0;
  logic [127:0] sres = '0;
  always @(posedge clk) begin
    irdy_q <= md4_irdy;
    if (md4_irdy && !irdy_q) begin
      ph   <= 1;
      scnt <= stale_len;
      sres <= md4_fn(md4_in_a, md4_in_b, md4_in_c, md4_in_d, md4_data);
    end else if (ph == 1) begin
      if (scnt == 0) begin md4_ordy <= 1'b0; ph <= 2; scnt <= lat; end
      else scnt <= scnt - 1;
    end else if (ph == 2 && !md4_irdy) begin
      if (scnt == 0) begin
        md4_ordy <= 1'b1;
        {md4_out_a, md4_out_b, md4_out_c, md4_out_d} <= sres;
        ph <= 0;
      end else scnt <= scnt - 1;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // reference arbitration state
  bit busy_m = 0, post_done = 0, saw_done = 0;
  int ptr_m = 0, lane_m = 0, busy_cyc = 0, irdy_n = 0, dn_tot = 0;
  int dn_cnt [NR];
  int glog [$];
  logic [511:0] blk_m = '0;
  logic [127:0] exp_res = '0, res_m = '0;
  logic [31:0]  hd_m = '0;

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic int oh2idx(input logic [NR-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int l = 0; l < NR; l++) if (v[l]) return l;
    return -1;
  endfunction

  task automatic rand_data();
    for (int w = 0; w < 16 * NR; w++) req_data[32*w +: 32] = $urandom();
  endtask

  // one clock: the DUT sees the current inputs, then outputs are checked
  task automatic step();
    logic [NR-1:0] rq;
    logic [512*NR-1:0] rd;
    int p;
    bit done_now;
    rq = req; rd = req_data; done_now = 0;
    @(posedge clk); #1;
    if (!busy_m) begin
      p = post_done ? -1 : pick(rq, ptr_m);
      post_done = 0;
      chk("gnt", 512'(gnt), (p < 0) ? 512'(0) : (512'(1) << p));
      chk("done_idle", 512'(done), 512'(0));
      if (p >= 0) begin
        busy_m = 1; lane_m = p; blk_m = rd[512*p +: 512];
        exp_res = md4_fn(IA, IB, IC, ID, blk_m);
        irdy_n = 0; busy_cyc = 0;
        glog.push_back(oh2idx(gnt));
      end else chk("irdy_idle", 512'(md4_irdy), 512'(0));
    end
    if (busy_m) begin
      busy_cyc++;
      if (md4_irdy) irdy_n++;
      chk("gnt_hold", 512'(gnt), 512'(1) << lane_m);
      chk("md4_data", md4_data, blk_m);
      chk("md4_in", 512'({md4_in_a, md4_in_b, md4_in_c, md4_in_d}), 512'({IA, IB, IC, ID}));
      if (done != '0) begin
        chk("done_lane", 512'(done), 512'(1) << lane_m);
        chk("irdy_width", 512'(irdy_n), 512'(HOLD));
        res_m = exp_res; busy_m = 0; post_done = 1; ptr_m = (lane_m + 1) % NR;
        dn_cnt[lane_m]++; dn_tot++; saw_done = 1; done_now = 1;
      end else if (busy_cyc > 200) begin
        chk("busy_timeout", 512'(busy_cyc), 512'(200));
        busy_m = 0;
      end
    end
    chk("result", 512'(result), 512'(res_m));
    chk("hashes_done", 512'(hashes_done), 512'(hd_m));
    if (done_now) hd_m = hd_m + 32'd1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req = '0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_gnt_done_irdy", 512'({gnt, done, md4_irdy}), 512'(0));
    chk("rst_in", 512'({md4_in_a, md4_in_b, md4_in_c, md4_in_d}), 512'(0));
    chk("rst_data", md4_data, 512'(0));
    chk("rst_result", 512'(result), 512'(0));
    chk("rst_hashes", 512'(hashes_done), 512'(0));
    chk("rst_aux", 512'(|{gnt_h1, done_h1, res_h1, hd_h1, ia_h1, ib_h1, ic_h1, id_h1, irdy_h1, dat_h1,
                          gnt_h15, done_h15, res_h15, hd_h15, ia_h15, ib_h15, ic_h15, id_h15,
                          irdy_h15, dat_h15}), 512'(0));
    rst = 1'b0;
    busy_m = 0; post_done = 0; ptr_m = 0; hd_m = '0; res_m = '0;
  endtask

  task automatic wait_done(input int max);
    int c;
    c = 0;
    while (!saw_done && c < max) begin step(); c++; end
    chk("wait_done", 512'(saw_done), 512'(1));
  endtask

  task automatic clr_stats();
    glog.delete();
    foreach (dn_cnt[l]) dn_cnt[l] = 0;
    dn_tot = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c15, snap;
    clr_stats();
    do_reset(3);

    // trigger width at the extreme hold settings
    c1 = 0; c15 = 0; req_h = 4'b0001;
    for (int i = 0; i < 25; i++) begin
      step();
      if (i == 0) req_h = '0;
      if (irdy_h1) c1++;
      if (irdy_h15) c15++;
    end
    chk("irdy_hold1", 512'(c1), 512'(1));
    chk("irdy_hold15", 512'(c15), 512'(15));

    // empty NT password block on lane 0
    clr_stats(); rand_data(); req_data[511:0] = 512'h80;
    stale_len = 0; lat = 3; saw_done = 0; req = 4'b0001;
    step(); req = '0;
    wait_done(100);
    repeat (3) step();
    chk("nt_result", 512'(result), 512'(128'he0cfd631_31e96ad1_d7593cb7_c089c0e0));
    chk("nt_hashes", 512'(hashes_done), 512'(1));
    chk("nt_dones", 512'(dn_cnt[0]), 512'(1));
    chk("nt_grant", 512'(glog[0]), 512'(0));

    // all lanes requesting continuously: strict rotation
    do_reset(2); clr_stats(); req = 4'hf;
    for (int i = 0; i < 400 && dn_tot < 8; i++) begin rand_data(); step(); end
    req = '0;
    repeat (4) step();
    chk("rot_count", 512'(glog.size()), 512'(8));
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("rot_order", 512'(glog[i]), 512'(i % 4));
    for (int i = 1; i < glog.size(); i++) chk("rot_repeat", 512'(glog[i] == glog[i-1]), 512'(0));
    chk("rot_hashes", 512'(hashes_done), 512'(8));

    // lane 1 drops its request right after the grant
    clr_stats(); saw_done = 0; req = 4'b0010;
    step(); req = '0;
    wait_done(100);
    repeat (20) step();
    chk("drop_done", 512'(dn_cnt[1]), 512'(1));
    chk("drop_grants", 512'(glog.size()), 512'(1));

    // ordy left high well into the next block
    clr_stats(); saw_done = 0; stale_len = 5; lat = 2; req = 4'b0100;
    step(); req = '0;
    wait_done(100);
    repeat (20) step();
    chk("stale_dones", 512'(dn_tot), 512'(1));

    // reset while waiting for the result
    stale_len = 0; lat = 10; saw_done = 0; req = 4'b0100;
    step(); req = '0;
    wait_done(100);
    repeat (2) step();
    req = 4'b0100; step(); req = '0;
    repeat (6) step();
    do_reset(1);
    snap = dn_tot;
    repeat (25) step();
    chk("abort_nodone", 512'(dn_tot), 512'(snap));
    chk("abort_result", 512'(result), 512'(0));
    lat = 3; saw_done = 0; req = 4'b1100;
    step(); req = '0;
    chk("abort_regrant", 512'(oh2idx(gnt)), 512'(2));
    wait_done(100);

    // random traffic
    clr_stats();
    for (int i = 0; i < 800; i++) begin
      for (int l = 0; l < NR; l++) if ($urandom_range(0, 5) == 0) req[l] = ~req[l];
      rand_data();
      stale_len = $urandom_range(0, 4);
      lat = $urandom_range(1, 6);
      step();
    end
    req = '0;
    for (int i = 0; i < 300 && (busy_m || post_done); i++) step();
    repeat (3) step();
    chk("rand_total", 512'(hashes_done), 512'(hd_m));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/md4_arbiter.md
MD4_ARBITER -- requirements
Module: md4_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester lanes (2..8).
REQ-002 Parameter IRDY_HOLD, default 2, cycles md4_irdy stays high per trigger (1..15).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-lane request level.
REQ-006 req_data  input  512*NUM_REQ  lane i message block at bits [512*i+511 : 512*i].
REQ-007 gnt  output  NUM_REQ  one-hot grant; all zero when idle.
REQ-008 done  output  NUM_REQ  one-cycle completion pulse for the granted lane.
REQ-009 result  output  128  {a,b,c,d} of the last completed MD4 block, a in bits [127:96].
REQ-010 hashes_done  output  32  count of completed blocks.
REQ-011 md4_irdy  output  1  trigger to the shared md4block.
REQ-012 md4_in_a, md4_in_b, md4_in_c, md4_in_d  output  32 each  chaining inputs.
REQ-013 md4_data  output  512  message block to md4block.
REQ-014 md4_ordy  input  1  md4block result ready.
REQ-015 md4_out_a, md4_out_b, md4_out_c, md4_out_d  input  32 each  md4block result words.

Function
REQ-016 The block SHALL implement states IDLE, TRIG, LOWER, WAIT_LO, WAIT_HI and DONE.
REQ-017 IDLE, with any req bit set: select the first set lane at or after rr_ptr, wrapping modulo NUM_REQ; set gnt to that lane, latch its req_data into md4_data, load md4_in_a..d = 67452301, efcdab89, 98badcfe, 10325476; go to TRIG.
REQ-018 IDLE, with req all zero: stay in IDLE with gnt = 0.
REQ-019 TRIG: md4_irdy is high for exactly IRDY_HOLD cycles (down-counter), then the block goes to LOWER.
REQ-020 LOWER: md4_irdy is driven low for one cycle, then WAIT_LO.
REQ-021 WAIT_LO: wait until md4_ordy = 0, then WAIT_HI; a stale ordy left high from the previous block is never accepted.
REQ-022 WAIT_HI: when md4_ordy = 1, capture md4_out_a..d into result and go to DONE.
REQ-023 DONE: pulse done[granted lane] for one cycle, increment hashes_done (wraps at 2^32), set rr_ptr = granted lane + 1 mod NUM_REQ, clear gnt, return to IDLE.
REQ-024 Minimum request-to-done latency SHALL be IRDY_HOLD + 3 + (md4block latency) cycles; arbitration adds no cycle beyond IDLE.
REQ-025 md4_data and md4_in_* SHALL be stable from TRIG through DONE; req_data changes after grant are ignored.
REQ-026 A req dropped after grant does not abort: the block completes and done still pulses.
REQ-027 A req dropped before grant is never served.
REQ-028 A req still high in the cycle after done is a new request; it is arbitrated at the next IDLE with lowered priority.
REQ-029 result SHALL hold its value until the next DONE.
REQ-030 At most one lane is granted at any time; done is never asserted outside DONE.

Reset
REQ-031 rst SHALL force state IDLE, gnt = 0, done = 0, md4_irdy = 0, md4_in_* = 0, md4_data = 0, result = 0, hashes_done = 0, rr_ptr = 0, hold counter = 0.
REQ-032 rst in any state SHALL abandon the in-flight block: no done pulse, and a later md4_ordy is not mistaken for a result.
REQ-033 rst takes priority over every simultaneous event.

Verification
REQ-034 Single lane 0 with the empty NT password block, real md4block -> gnt = 0001, one done[0] pulse, result = e0cfd631_31e96ad1_d7593cb7_c089c0e0, hashes_done = 1.
REQ-035 All four lanes held high for 8 completions -> grant order 0,1,2,3,0,1,2,3, no lane granted twice in a row, hashes_done = 8.
REQ-036 md4_ordy stub held high when TRIG is entered -> no capture until ordy falls and rises again; exactly one done.
REQ-037 rst pulsed during WAIT_HI, then md4_ordy = 1 -> no done, result = 0, next req on lane 2 granted from rr_ptr = 0.
REQ-038 Lane 1 drops req in the cycle after grant -> done[1] still pulses once; lane 1 is not re-granted.
REQ-039 IRDY_HOLD = 1 and IRDY_HOLD = 15 -> md4_irdy high for exactly 1 and 15 cycles respectively.
